// File: rtl/demultiplexer_1_4_buffered_pkg.sv
// Shared types and constants for the buffered 1:4 demultiplexer and its slot FIFOs.
// Select and occupancy encodings live here so the top level and the FIFO agree on them.
package demultiplexer_1_4_buffered_pkg;

  localparam int WIDTH_DEFAULT = 4;
  localparam int DEPTH         = 2;
  localparam int NUM_DEST      = 4;

  typedef enum logic [1:0] {
    SEL_O0 = 2'b00,
    SEL_O1 = 2'b01,
    SEL_O2 = 2'b10,
    SEL_O3 = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_e;

  // One-hot destination mask for a select value.
  function automatic logic [NUM_DEST-1:0] sel_onehot(input sel_e s);
    logic [NUM_DEST-1:0] base;
    base = 4'b0001;
    return base << s;
  endfunction

endpackage

// File: rtl/demultiplexer_1_4_buffered_slot_fifo.sv
// Two-entry FIFO behind one demultiplexer destination; 1-bit pointers wrap modulo 2.
// Flush clears occupancy and pointers but leaves storage untouched.
module demux_slot_fifo
  import demultiplexer_1_4_buffered_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  cnt_e             count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Push is refused when full even if a pop lands in the same cycle.
  assign push_ok = push_i && (count_q != CNT_FULL)  && !flush_i;
  assign pop_ok  = pop_i  && (count_q != CNT_EMPTY) && !flush_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = CNT_EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = (count_q == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
        2'b01:   count_d = (count_q == CNT_FULL)  ? CNT_ONE : CNT_EMPTY;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= CNT_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign valid_o = (count_q != CNT_EMPTY);
  assign full_o  = (count_q == CNT_FULL);
  // Stale storage is hidden once the slot drains.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/demultiplexer_1_4_buffered.sv
// Routes one source bus into one of four buffered destinations chosen by {a,b}.
// Holds only select decode, the ready mux and push fan-out; buffering is in the slots.
module demultiplexer_1_4_buffered
  import demultiplexer_1_4_buffered_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] o_0,
  output logic [WIDTH-1:0] o_1,
  output logic [WIDTH-1:0] o_2,
  output logic [WIDTH-1:0] o_3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ack
);

  sel_e                sel;
  logic [NUM_DEST-1:0] full;
  logic [NUM_DEST-1:0] push_en;
  logic [WIDTH-1:0]    head [NUM_DEST];

  assign sel = sel_e'({a, b});

  // reset_n gates ready so nothing is advertised while held in reset.
  assign i_ready = !full[sel] && !flush && reset_n;
  assign push_en = (i_valid && i_ready) ? sel_onehot(sel) : '0;

  generate
    for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_slot
      demux_slot_fifo #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk     (clk),
        .rst_n_i (reset_n),
        .push_i  (push_en[gi]),
        .pop_i   (o_ack[gi]),
        .flush_i (flush),
        .data_i  (i),
        .data_o  (head[gi]),
        .valid_o (o_valid[gi]),
        .full_o  (full[gi])
      );
    end
  endgenerate

  assign o_0 = head[0];
  assign o_1 = head[1];
  assign o_2 = head[2];
  assign o_3 = head[3];

endmodule

// File: tb/tb_demultiplexer_1_4_buffered.sv
// Directed plus randomized bench for the buffered 1:4 demultiplexer.
// Reference model: per-destination arrays with head at index 0, shifted on pop.
module tb_demultiplexer_1_4_buffered;

  logic       clk;
  logic       reset_n;
  logic       a, b;
  logic [3:0] i;
  logic       i_valid;
  logic       i_ready;
  logic       flush;
  logic [3:0] o_0, o_1, o_2, o_3;
  logic [3:0] o_valid;
  logic [3:0] o_ack;

  int total;
  int passed;

  logic [3:0] m_data [4][2];
  int         m_cnt  [4];

  demultiplexer_1_4_buffered #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .flush   (flush),
    .o_0     (o_0),
    .o_1     (o_1),
    .o_2     (o_2),
    .o_3     (o_3),
    .o_valid (o_valid),
    .o_ack   (o_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] dut_out(input int k);
    case (k)
      0:       return o_0;
      1:       return o_1;
      2:       return o_2;
      default: return o_3;
    endcase
  endfunction

  function automatic logic model_ready(input int s);
    return reset_n && !flush && (m_cnt[s] < 2);
  endfunction

  task automatic check_all(input string tag);
    int s;
    s = {30'd0, a, b};
    chk($sformatf("%s i_ready", tag), {31'd0, i_ready}, {31'd0, model_ready(s)});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s o_valid[%0d]", tag, k), {31'd0, o_valid[k]}, {31'd0, (m_cnt[k] > 0)});
      chk($sformatf("%s o_%0d", tag, k), {28'd0, dut_out(k)},
          {28'd0, (m_cnt[k] > 0) ? m_data[k][0] : 4'h0});
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  // Applies inputs for one cycle, checks against the model, then advances the model.
  task automatic step(input string tag, input logic ta, input logic tb_, input logic [3:0] td,
                      input logic tv, input logic tf, input logic [3:0] tk);
    int  s;
    logic acc;
    a = ta; b = tb_; i = td; i_valid = tv; flush = tf; o_ack = tk;
    #1;
    check_all(tag);
    s   = {30'd0, ta, tb_};
    acc = tv && model_ready(s);
    @(posedge clk);
    if (tf) begin
      clear_model();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (tk[k] && m_cnt[k] > 0) begin
          m_data[k][0] = m_data[k][1];
          m_cnt[k]     = m_cnt[k] - 1;
        end
      end
      if (acc) begin
        m_data[s][m_cnt[s]] = td;
        m_cnt[s]            = m_cnt[s] + 1;
        $display("push sel=%0d data=%h", s, td);
      end
    end
    #1;
  endtask

  initial begin
    total = 0; passed = 0;
    reset_n = 1'b0; a = 0; b = 0; i = 0; i_valid = 0; flush = 0; o_ack = 0;
    clear_model();
    for (int k = 0; k < 4; k++) begin
      m_data[k][0] = 4'h0;
      m_data[k][1] = 4'h0;
    end
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready after reset", {31'd0, i_ready}, 32'd1);

    // 1: single push to o_2, then pop
    step("t1 push", 1, 0, 4'hA, 1, 0, 4'b0000);
    chk("t1 o_valid", {28'd0, o_valid}, 32'h4);
    chk("t1 o_2", {28'd0, o_2}, 32'hA);
    step("t1 ack", 0, 0, 4'h0, 0, 0, 4'b0100);
    chk("t1 o_valid after ack", {28'd0, o_valid}, 32'h0);

    // 2: fill o_1, third push stalls until one ack
    step("t2 p3", 0, 1, 4'h3, 1, 0, 4'b0000);
    step("t2 p5", 0, 1, 4'h5, 1, 0, 4'b0000);
    chk("t2 full not ready", {31'd0, i_ready}, 32'd0);
    step("t2 p7 blocked ack", 0, 1, 4'h7, 1, 0, 4'b0010);
    chk("t2 o_1 after ack", {28'd0, o_1}, 32'h5);
    chk("t2 ready back", {31'd0, i_ready}, 32'd1);
    step("t2 p7", 0, 1, 4'h7, 1, 0, 4'b0000);
    step("t2 drain", 0, 0, 4'h0, 0, 0, 4'b1111);
    step("t2 drain2", 0, 0, 4'h0, 0, 0, 4'b1111);

    // 3: simultaneous push/pop at count 1; full slot with ack still not ready
    step("t3 p1", 0, 0, 4'h1, 1, 0, 4'b0000);
    step("t3 push+pop", 0, 0, 4'h2, 1, 0, 4'b0001);
    chk("t3 o_0", {28'd0, o_0}, 32'h2);
    step("t3 f3a", 1, 1, 4'h8, 1, 0, 4'b0000);
    step("t3 f3b", 1, 1, 4'h9, 1, 0, 4'b0000);
    a = 1; b = 1; o_ack = 4'b1000; #1;
    chk("t3 full+ack ready", {31'd0, i_ready}, 32'd0);
    step("t3 ack3", 1, 1, 4'h0, 1, 0, 4'b1001);
    step("t3 drain", 0, 0, 4'h0, 0, 0, 4'b1111);
    step("t3 drain2", 0, 0, 4'h0, 0, 0, 4'b1111);

    // 4: interleaved destinations, dual pop
    step("t4 a", 0, 0, 4'h1, 1, 0, 4'b0000);
    step("t4 b", 1, 1, 4'h2, 1, 0, 4'b0000);
    step("t4 c", 0, 0, 4'h3, 1, 0, 4'b0000);
    step("t4 d", 1, 1, 4'h4, 1, 0, 4'b0000);
    chk("t4 o_0 head", {28'd0, o_0}, 32'h1);
    chk("t4 o_3 head", {28'd0, o_3}, 32'h2);
    step("t4 pop both", 0, 0, 4'h0, 0, 0, 4'b1001);
    chk("t4 o_0 second", {28'd0, o_0}, 32'h3);
    chk("t4 o_3 second", {28'd0, o_3}, 32'h4);
    step("t4 pop both2", 0, 0, 4'h0, 0, 0, 4'b1001);

    // 5: fill all, then flush overriding push and pops
    for (int k = 0; k < 8; k++) begin
      step("t5 fill", k[1], k[0], 4'(k + 5), 1, 0, 4'b0000);
    end
    a = 0; b = 0; i_valid = 1; flush = 1; o_ack = 4'b1111; #1;
    chk("t5 ready in flush", {31'd0, i_ready}, 32'd0);
    step("t5 flush", 0, 0, 4'hE, 1, 1, 4'b1111);
    chk("t5 o_valid", {28'd0, o_valid}, 32'h0);

    // 6: async reset between edges
    step("t6 p1", 1, 0, 4'hB, 1, 0, 4'b0000);
    step("t6 p2", 1, 0, 4'hC, 1, 0, 4'b0000);
    i_valid = 0; #2;
    reset_n = 1'b0;
    #1;
    clear_model();
    chk("t6 o_valid in reset", {28'd0, o_valid}, 32'h0);
    chk("t6 o_2 in reset", {28'd0, o_2}, 32'h0);
    chk("t6 ready in reset", {31'd0, i_ready}, 32'd0);
    @(posedge clk); #3;
    reset_n = 1'b1;
    step("t6 pF", 1, 0, 4'hF, 1, 0, 4'b0000);
    chk("t6 o_valid alone", {28'd0, o_valid}, 32'h4);
    chk("t6 o_2", {28'd0, o_2}, 32'hF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] rs;
      rs = 2'($urandom_range(0, 3));
      step("rand", rs[1], rs[0], 4'($urandom), 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0), 4'($urandom));
    end
    step("final", 0, 0, 4'h0, 0, 0, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
